alu_mul_seq: RTL and testbench
==============================

ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: i_clk and i_reset.
REQ-002 The block SHALL provide these ports:
- i_clk  in  1  system clock; all state updates on the rising edge
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  request a multiply; sampled only in IDLE
- i_multiplicand  in  8  operand M, latched on start
- i_multiplier  in  8  operand Q, latched on start
- o_busy  out  1  high from the cycle after start acceptance through the DONE cycle
- o_done  out  1  one-cycle pulse in the DONE state
- o_product  out  16  unsigned M*Q; valid from DONE, held until the next start or reset
- o_a  out  8  drives ALU i_a
- o_aluBus  out  8  drives ALU i_bus (operand B)
- i_aluBus  in  8  ALU registered result (ALU o_bus)
- i_aluCarry  in  1  ALU carry flag
- o_ctrlAluYNWE  out  1  active-low ALU result/flag write strobe
- o_ctrlAluNOE  out  1  active-low ALU output enable
- o_ctrlAluSub  out  1  ALU subtract/invert select; always 0 in this block
- o_ctrlAluOp  out  2  ALU op select; 00=add, 01=and, 10=xor, 11=shift

Function
REQ-003 The block SHALL compute the unsigned 8x8->16 shift-add product, using the attached ALU for every addition.
REQ-004 The block SHALL hold internal registers: M[7:0], hi accumulator P[7:0], low register Q[7:0], and a 3-bit bit counter.
REQ-005 The block SHALL implement states IDLE, SHIFT, ADD, ADDSHIFT and DONE.
REQ-006 IDLE: on i_start=1 the block SHALL latch M and Q, clear P and the counter, and go to ADD if Q[0]=1, otherwise to SHIFT.
REQ-007 ADD: the block SHALL drive o_a=P, o_aluBus=M, o_ctrlAluOp=00, o_ctrlAluSub=0 and o_ctrlAluYNWE=0 for exactly this one cycle, then go to ADDSHIFT.
REQ-008 ADDSHIFT: the block SHALL drive o_ctrlAluNOE=0 and load {P,Q} <= {i_aluCarry, i_aluBus, Q[7:1]} (9-bit carry plus the 8-bit sum, shifted right by 1).
REQ-009 SHIFT: the block SHALL load {P,Q} <= {1'b0, P, Q[7:1]}.
REQ-010 After SHIFT or ADDSHIFT the block SHALL increment the counter.
- If the counter was 7, next state SHALL be DONE.
- Otherwise next state SHALL be ADD if the new Q[0]=1, else SHIFT.
REQ-011 On entering DONE the block SHALL set o_product={P,Q}; in DONE it SHALL assert o_done=1, then return to IDLE.
REQ-012 Latency: o_done SHALL assert 9 + popcount(multiplier) cycles after the start-sampling edge.
REQ-013 i_start SHALL be ignored in every state other than IDLE, including DONE.
REQ-014 Outside ADD the block SHALL hold o_ctrlAluYNWE=1; outside ADDSHIFT it SHALL hold o_ctrlAluNOE=1.
REQ-015 Outside ADD the block SHALL hold o_a=0, o_aluBus=0, o_ctrlAluOp=00 and o_ctrlAluSub=0.
REQ-016 A multiplier of 0 SHALL produce 8 SHIFT cycles, no ALU writes, and product 0x0000.

Reset
REQ-017 On i_reset=1 at a clock edge, in any state including mid-operation, the block SHALL go to IDLE.
REQ-018 Reset values: o_busy=0, o_done=0, o_product=0, o_a=0, o_aluBus=0, o_ctrlAluYNWE=1, o_ctrlAluNOE=1, o_ctrlAluSub=0, o_ctrlAluOp=00; M, P, Q and the counter SHALL be 0.
REQ-019 Reset SHALL take priority over i_start in the same cycle.

Structure
REQ-020 The ALU op encodings (ADD/AND/XOR/SHIFT) and the state enumeration SHALL live in a shared package, alu_pkg, which the ALU also uses.
REQ-021 The block SHALL be a single module with no sub-modules; the counter and datapath SHALL be inline.

Verification
REQ-022 The bench SHALL instantiate the real ALU wired to the ALU-side ports and SHALL cover these scenarios:
- 0x0D*0x0B -> o_product=0x008F, o_done 12 cycles after start, three ADD cycles.
- 0xFF*0xFF -> 0xFE01, done at 17 cycles, i_aluCarry=1 captured in at least one ADDSHIFT.
- 0x37*0x00 -> 0x0000, done at 9 cycles, o_ctrlAluYNWE never 0.
- i_start pulsed during busy and during DONE -> ignored; product unchanged; o_done pulses exactly once.
- i_reset asserted 5 cycles into 0xFF*0xFF -> next cycle all outputs at reset values; then 0x02*0x03 -> 0x0006 at 11 cycles.
- Control check on every ADD: o_ctrlAluYNWE=0 for one cycle with o_a=P, o_aluBus=M, op=00, sub=0; o_ctrlAluNOE=0 in exactly the following cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU op encodings and multiplier sequencer state enumeration.
package alu_pkg;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_AND   = 2'b01,
      ALU_XOR   = 2'b10,
      ALU_SHIFT = 2'b11
   } alu_op_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SHIFT    = 3'd1,
      ST_ADD      = 3'd2,
      ST_ADDSHIFT = 3'd3,
      ST_DONE     = 3'd4
   } mul_state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// ALU control/data bundle between a sequencer (master) and the 8-bit ALU (slave).
interface alu_mul_seq_if;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [7:0] alu_res;
   logic       alu_carry;
   logic       ctrl_nwe;
   logic       ctrl_noe;
   logic       ctrl_sub;
   logic [1:0] ctrl_op;

   modport master (
      output alu_a, alu_b, ctrl_nwe, ctrl_noe, ctrl_sub, ctrl_op,
      input  alu_res, alu_carry
   );

   modport slave (
      input  alu_a, alu_b, ctrl_nwe, ctrl_noe, ctrl_sub, ctrl_op,
      output alu_res, alu_carry
   );
endinterface

// File: rtl/alu.sv
// 8-bit ALU with registered result/carry; write on ctrl_nwe low, result visible
// on the bus only while ctrl_noe is low (reads as zero otherwise).
module alu
   import alu_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_reset,
   alu_mul_seq_if.slave        alu_bus
);

   logic [7:0] r_res;
   logic       r_carry;
   logic [7:0] w_b;
   logic [8:0] w_sum;
   logic [7:0] w_res;
   logic       w_carry;

   // Subtract is a + ~b + 1, so the carry doubles as not-borrow.
   always_comb begin
      w_b     = alu_bus.ctrl_sub ? ~alu_bus.alu_b : alu_bus.alu_b;
      w_sum   = {1'b0, alu_bus.alu_a} + {1'b0, w_b} + {8'h00, alu_bus.ctrl_sub};
      w_res   = w_sum[7:0];
      w_carry = w_sum[8];
      case (alu_op_t'(alu_bus.ctrl_op))
         ALU_ADD:   begin w_res = w_sum[7:0];          w_carry = w_sum[8]; end
         ALU_AND:   begin w_res = alu_bus.alu_a & w_b; w_carry = 1'b0;     end
         ALU_XOR:   begin w_res = alu_bus.alu_a ^ w_b; w_carry = 1'b0;     end
         ALU_SHIFT: {w_carry, w_res} = {alu_bus.alu_a, 1'b0};
         default:   begin w_res = w_sum[7:0];          w_carry = w_sum[8]; end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_res   <= 8'h00;
         r_carry <= 1'b0;
      end else if (!alu_bus.ctrl_nwe) begin
         r_res   <= w_res;
         r_carry <= w_carry;
      end
   end

   assign alu_bus.alu_res   = alu_bus.ctrl_noe ? 8'h00 : r_res;
   assign alu_bus.alu_carry = r_carry;

endmodule

// File: rtl/alu_mul_seq.sv
// Unsigned 8x8->16 shift-add multiplier that borrows an external ALU for each add.
// Done pulses 9 + popcount(multiplier) cycles after start is sampled in IDLE.
module alu_mul_seq
   import alu_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [7:0]  i_multiplicand,
   input  logic [7:0]  i_multiplier,
   output logic        o_busy,
   output logic        o_done,
   output logic [15:0] o_product,
   output logic [7:0]  o_a,
   output logic [7:0]  o_aluBus,
   input  logic [7:0]  i_aluBus,
   input  logic        i_aluCarry,
   output logic        o_ctrlAluYNWE,
   output logic        o_ctrlAluNOE,
   output logic        o_ctrlAluSub,
   output logic [1:0]  o_ctrlAluOp
);

   mul_state_t  r_state;
   mul_state_t  w_state_nxt;
   logic [7:0]  r_m;
   logic [7:0]  r_p;
   logic [7:0]  r_q;
   logic [2:0]  r_cnt;
   logic [15:0] r_product;
   logic [7:0]  w_p_nxt;
   logic [7:0]  w_q_nxt;
   logic        w_last;
   logic        w_step;

   assign w_last = (r_cnt == 3'd7);
   assign w_step = (r_state == ST_SHIFT) || (r_state == ST_ADDSHIFT);

   always_comb begin
      w_state_nxt   = r_state;
      w_p_nxt       = r_p;
      w_q_nxt       = r_q;
      o_a           = 8'h00;
      o_aluBus      = 8'h00;
      o_ctrlAluYNWE = 1'b1;
      o_ctrlAluNOE  = 1'b1;
      o_ctrlAluSub  = 1'b0;
      o_ctrlAluOp   = ALU_ADD;
      case (r_state)
         ST_IDLE: begin
            if (i_start) w_state_nxt = i_multiplier[0] ? ST_ADD : ST_SHIFT;
         end
         ST_ADD: begin
            o_a           = r_p;
            o_aluBus      = r_m;
            o_ctrlAluYNWE = 1'b0;
            w_state_nxt   = ST_ADDSHIFT;
         end
         // The ALU's registered sum plus its carry form the 9-bit partial product.
         ST_ADDSHIFT: begin
            o_ctrlAluNOE       = 1'b0;
            {w_p_nxt, w_q_nxt} = {i_aluCarry, i_aluBus, r_q[7:1]};
         end
         ST_SHIFT: begin
            {w_p_nxt, w_q_nxt} = {1'b0, r_p, r_q[7:1]};
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      if (w_step) begin
         if (w_last)          w_state_nxt = ST_DONE;
         else if (w_q_nxt[0]) w_state_nxt = ST_ADD;
         else                 w_state_nxt = ST_SHIFT;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= ST_IDLE;
         r_m       <= 8'h00;
         r_p       <= 8'h00;
         r_q       <= 8'h00;
         r_cnt     <= 3'd0;
         r_product <= 16'h0000;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_IDLE && i_start) begin
            r_m   <= i_multiplicand;
            r_q   <= i_multiplier;
            r_p   <= 8'h00;
            r_cnt <= 3'd0;
         end
         if (w_step) begin
            r_p   <= w_p_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt + 3'd1;
            // Publish the product on the same edge that enters DONE.
            if (w_last) r_product <= {w_p_nxt, w_q_nxt};
         end
      end
   end

   assign o_busy    = (r_state != ST_IDLE);
   assign o_done    = (r_state == ST_DONE);
   assign o_product = r_product;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq wired to the real ALU through the shared interface.
module tb_alu_mul_seq;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  mcand;
   logic [7:0]  mplier;
   logic        o_busy;
   logic        o_done;
   logic [15:0] o_product;
   logic [7:0]  o_a;
   logic [7:0]  o_aluBus;
   logic [7:0]  alu_res;
   logic        alu_carry;
   logic        o_ynwe;
   logic        o_noe;
   logic        o_sub;
   logic [1:0]  o_op;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_mul_seq_if u_if ();

   assign u_if.alu_a    = o_a;
   assign u_if.alu_b    = o_aluBus;
   assign u_if.ctrl_nwe = o_ynwe;
   assign u_if.ctrl_noe = o_noe;
   assign u_if.ctrl_sub = o_sub;
   assign u_if.ctrl_op  = o_op;
   assign alu_res       = u_if.alu_res;
   assign alu_carry     = u_if.alu_carry;

   alu u_alu (
      .i_clk   (clk),
      .i_reset (rst),
      .alu_bus (u_if.slave)
   );

   alu_mul_seq u_dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_start        (start),
      .i_multiplicand (mcand),
      .i_multiplier   (mplier),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_product      (o_product),
      .o_a            (o_a),
      .o_aluBus       (o_aluBus),
      .i_aluBus       (alu_res),
      .i_aluCarry     (alu_carry),
      .o_ctrlAluYNWE  (o_ynwe),
      .o_ctrlAluNOE   (o_noe),
      .o_ctrlAluSub   (o_sub),
      .o_ctrlAluOp    (o_op)
   );

   typedef struct {
      logic [7:0]  m;
      logic [7:0]  q;
      logic [15:0] prod;
      int          lat;
      int          adds;
      bit          need_carry;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string name);
      chk(name, {o_busy, o_done, o_ynwe, o_noe, o_sub, o_op, o_a, o_aluBus},
          {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00});
      chk({name, "_product"}, o_product, 32'h0);
   endtask

   // Runs one multiply, checking ALU control every cycle; abort_at>0 stops early.
   task automatic do_mul(input logic [7:0] m, input logic [7:0] q, input logic [15:0] exp_prod,
                         input int exp_lat, input int exp_adds, input bit need_carry,
                         input bit glitch, input int abort_at);
      logic [7:0] exp_a [8];
      logic [7:0] p;
      logic [7:0] qq;
      logic [8:0] s9;
      int  na;
      int  k;
      int  n;
      int  lat;
      bit  is_add;
      bit  prev_add;
      bit  saw_carry;
      bit  done_seen;

      p  = 8'h00;
      qq = q;
      na = 0;
      for (int i = 0; i < 8; i++) begin
         exp_a[i] = 8'h00;
      end
      for (int i = 0; i < 8; i++) begin
         if (qq[0]) begin
            exp_a[na] = p;
            na++;
            s9 = {1'b0, p} + {1'b0, m};
            {p, qq} = {s9, qq[7:1]};
         end else begin
            {p, qq} = {1'b0, p, qq[7:1]};
         end
      end

      @(negedge clk);
      mcand  = m;
      mplier = q;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;

      n = 1; k = 0; lat = 0;
      prev_add = 1'b0; saw_carry = 1'b0; done_seen = 1'b0;
      while (n <= 40 && !done_seen) begin
         @(negedge clk);
         is_add = (o_ynwe == 1'b0);
         chk("busy", {31'h0, o_busy}, 32'h1);
         chk("noe_after_add", {31'h0, o_noe}, prev_add ? 32'h0 : 32'h1);
         if (is_add) begin
            if (k < 8) chk("add_a_is_p", o_a, exp_a[k]);
            chk("add_bus_is_m", o_aluBus, m);
            chk("add_op_sub", {o_op, o_sub}, 32'h0);
            k++;
         end else begin
            chk("quiet_alu_ports", {o_a, o_aluBus, o_op, o_sub}, 32'h0);
         end
         if (!o_noe && alu_carry) saw_carry = 1'b1;
         if (o_done) begin
            done_seen = 1'b1;
            lat = n;
         end else begin
            if (abort_at != 0 && n == abort_at) return;
            if (glitch) begin
               start = (n == 3);
               mcand = 8'hAA;
               mplier = 8'h55;
            end
            prev_add = is_add;
            @(posedge clk);
            n++;
         end
      end

      chk("done_latency", lat, exp_lat);
      if (!done_seen) return;
      chk("product", o_product, exp_prod);
      chk("add_cycles", k, exp_adds);
      if (need_carry) chk("carry_captured", {31'h0, saw_carry}, 32'h1);

      if (glitch) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_idle", {o_busy, o_done}, 32'h0);
         chk("product_held", o_product, exp_prod);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      vecs[0] = '{8'h0D, 8'h0B, 16'h008F, 12, 3, 1'b0};
      vecs[1] = '{8'hFF, 8'hFF, 16'hFE01, 17, 8, 1'b1};
      vecs[2] = '{8'h37, 8'h00, 16'h0000,  9, 0, 1'b0};
      vecs[3] = '{8'h80, 8'h80, 16'h4000, 10, 1, 1'b0};
      vecs[4] = '{8'hFF, 8'h01, 16'h00FF, 10, 1, 1'b0};
      vecs[5] = '{8'h10, 8'hF0, 16'h0F00, 13, 4, 1'b0};

      rst    = 1'b1;
      start  = 1'b0;
      mcand  = 8'h00;
      mplier = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset_state");
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         do_mul(vecs[i].m, vecs[i].q, vecs[i].prod, vecs[i].lat, vecs[i].adds,
                vecs[i].need_carry, 1'b0, 0);
      end

      // Start pulses mid-operation and during DONE must be ignored.
      do_mul(8'h0D, 8'h0B, 16'h008F, 12, 3, 1'b0, 1'b1, 0);

      // Reset five cycles into a long multiply, with start asserted alongside it.
      do_mul(8'hFF, 8'hFF, 16'hFE01, 17, 8, 1'b1, 1'b0, 5);
      rst    = 1'b1;
      start  = 1'b1;
      mcand  = 8'h12;
      mplier = 8'h34;
      @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("mid_op_reset");
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("reset_beats_start", {31'h0, o_busy}, 32'h0);

      do_mul(8'h02, 8'h03, 16'h0006, 11, 2, 1'b0, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
